// File: rtl/qk_score_engine_pkg.sv
// Shared types and sizing helpers for the tiled Q.K^T score engine.
package qk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Wide enough for any tile/query position comparison in the mask logic.
    typedef logic [15:0] tile_idx_t;

    function automatic int acc_w(input int dw, input int head_dim);
        return 2 * dw + $clog2(head_dim) + 1;
    endfunction

    // Sign-extended most negative value; callers truncate to their own width.
    function automatic logic signed [63:0] mask_val(input int aw);
        logic signed [63:0] v;
        v = {64{1'b1}} << (aw - 1);
        return v;
    endfunction

endpackage

// File: rtl/qk_score_engine_if.sv
// Job-request and score-stream bundle between operand buffers, engine and softmax.
interface qk_score_engine_if
    import qk_pkg::*;
#(
    parameter int HEAD_DIM = 4,
    parameter int SEQ_LEN  = 8,
    parameter int NUM_Q    = 2,
    parameter int LANES    = 2,
    parameter int DW       = 4,
    parameter int ACC_W    = acc_w(DW, HEAD_DIM)
) ();
    logic                                      start_valid;
    logic                                      start_ready;
    logic                                      causal_en;
    logic [$clog2(SEQ_LEN):0]                  q_offset;
    logic [NUM_Q-1:0][HEAD_DIM-1:0][DW-1:0]    q_mat;
    logic [SEQ_LEN-1:0][HEAD_DIM-1:0][DW-1:0]  k_mat;
    logic                                      score_valid;
    logic                                      score_ready;
    logic [LANES-1:0][ACC_W-1:0]               score_data;
    logic [LANES-1:0]                          score_mask;
    logic [$clog2(NUM_Q):0]                    score_q_idx;
    logic [$clog2(SEQ_LEN):0]                  score_k_base;
    logic                                      score_last;
    logic                                      done;

    modport master (
        output start_valid, causal_en, q_offset, q_mat, k_mat, score_ready,
        input  start_ready, score_valid, score_data, score_mask, score_q_idx,
               score_k_base, score_last, done
    );

    modport slave (
        input  start_valid, causal_en, q_offset, q_mat, k_mat, score_ready,
        output start_ready, score_valid, score_data, score_mask, score_q_idx,
               score_k_base, score_last, done
    );
endinterface

// File: rtl/qk_score_engine_mac_lane.sv
// One dot-product lane: full-precision signed multiply, sign-extended accumulate.
module qk_mac_lane #(
    parameter int DW    = 4,
    parameter int ACC_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_first,
    input  logic                    en,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] r_acc;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(ACC_W - 2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_base     = clr_first ? '0 : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_base + w_prod_ext;
        end
    end

    assign acc = r_acc;
endmodule

// File: rtl/qk_score_engine.sv
// Tiled multi-query Q.K^T scorer: LANES key rows per tile, optional causal mask,
// tiles streamed over valid/ready.
module qk_score_engine
    import qk_pkg::*;
#(
    parameter int HEAD_DIM = 4,
    parameter int SEQ_LEN  = 8,
    parameter int NUM_Q    = 2,
    parameter int LANES    = 2,
    parameter int DW       = 4,
    parameter int ACC_W    = acc_w(DW, HEAD_DIM)
) (
    input logic              clk,
    input logic              rst_n,
    qk_score_engine_if.slave bus
);
    localparam int QW  = $clog2(NUM_Q) + 1;
    localparam int KW  = $clog2(SEQ_LEN) + 1;
    localparam int DIW = $clog2(HEAD_DIM) + 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MAC  = MAC;
    localparam logic [1:0] ST_OUT  = OUT;

    localparam logic [ACC_W-1:0] MASK_VAL = ACC_W'(mask_val(ACC_W));
    localparam logic [KW-1:0]    K_LAST   = KW'(SEQ_LEN - LANES);
    localparam logic [KW-1:0]    K_STEP   = KW'(LANES);
    localparam logic [QW-1:0]    Q_LAST   = QW'(NUM_Q - 1);
    localparam logic [DIW-1:0]   D_LAST   = DIW'(HEAD_DIM - 1);

    logic [1:0]       r_state;
    logic             r_causal;
    logic [KW-1:0]    r_q_off;
    logic [QW-1:0]    r_q_idx;
    logic [KW-1:0]    r_k_base;
    logic [DIW-1:0]   r_d_idx;
    logic [LANES-1:0] r_mask;
    logic             r_done;

    logic             w_start_hs;
    logic             w_at_last;
    logic             w_k_wrap;
    logic [QW-1:0]    w_q_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic [LANES-1:0] w_mask_start;
    logic [LANES-1:0] w_mask_nxt;
    logic             w_mac_en;
    logic             w_clr_first;

    // Lane l of tile (q_idx, k_base) is masked when its key lies after the query position.
    function automatic logic [LANES-1:0] calc_mask(
        input logic          causal,
        input logic [KW-1:0] q_off,
        input logic [QW-1:0] q_idx,
        input logic [KW-1:0] k_base
    );
        tile_idx_t limit;
        calc_mask = '0;
        limit = tile_idx_t'(q_off) + tile_idx_t'(q_idx);
        for (int l = 0; l < LANES; l++) begin
            calc_mask[l] = causal && ((tile_idx_t'(k_base) + tile_idx_t'(l)) > limit);
        end
    endfunction

    assign w_start_hs   = bus.start_valid && bus.start_ready;
    assign w_k_wrap     = (r_k_base == K_LAST);
    assign w_at_last    = w_k_wrap && (r_q_idx == Q_LAST);
    assign w_q_nxt      = w_k_wrap ? r_q_idx + 1'b1 : r_q_idx;
    assign w_k_nxt      = w_k_wrap ? '0 : r_k_base + K_STEP;
    assign w_mask_start = calc_mask(bus.causal_en, bus.q_offset, '0, '0);
    assign w_mask_nxt   = calc_mask(r_causal, r_q_off, w_q_nxt, w_k_nxt);
    assign w_mac_en     = (r_state == ST_MAC);
    assign w_clr_first  = (r_d_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_causal <= 1'b0;
            r_q_off  <= '0;
            r_q_idx  <= '0;
            r_k_base <= '0;
            r_d_idx  <= '0;
            r_mask   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_hs) begin
                        r_causal <= bus.causal_en;
                        r_q_off  <= bus.q_offset;
                        r_q_idx  <= '0;
                        r_k_base <= '0;
                        r_d_idx  <= '0;
                        r_mask   <= w_mask_start;
                        r_state  <= (&w_mask_start) ? ST_OUT : ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_d_idx == D_LAST) begin
                        r_d_idx <= '0;
                        r_state <= ST_OUT;
                    end else begin
                        r_d_idx <= r_d_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.score_ready) begin
                        if (w_at_last) begin
                            r_q_idx  <= '0;
                            r_k_base <= '0;
                            r_done   <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_q_idx  <= w_q_nxt;
                            r_k_base <= w_k_nxt;
                            r_mask   <= w_mask_nxt;
                            // A fully masked tile needs no MAC pass.
                            r_state  <= (&w_mask_nxt) ? ST_OUT : ST_MAC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [KW-1:0]           w_k_row;
            logic signed [ACC_W-1:0] w_acc;

            assign w_k_row = r_k_base + KW'(gi);

            qk_mac_lane #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr_first (w_clr_first),
                .en        (w_mac_en),
                .a         ($signed(bus.q_mat[r_q_idx][r_d_idx])),
                .b         ($signed(bus.k_mat[w_k_row][r_d_idx])),
                .acc       (w_acc)
            );

            // Accumulators hold still outside MAC, so the muxed output is stable in OUT.
            assign bus.score_data[gi] = r_mask[gi] ? MASK_VAL : w_acc;
        end
    endgenerate

    assign bus.start_ready  = (r_state == ST_IDLE) && !r_done;
    assign bus.score_valid  = (r_state == ST_OUT);
    assign bus.score_mask   = r_mask;
    assign bus.score_q_idx  = r_q_idx;
    assign bus.score_k_base = r_k_base;
    assign bus.score_last   = (r_state == ST_OUT) && w_at_last;
    assign bus.done         = r_done;
endmodule
